ads868x_up_regbank: RTL

Parametrised register bank for the ADS868x multi-channel ADC interface. It sits between the up_* register bus (fed by the AXI-Lite slave bridge) and the ADS868x sequencer/capture core, all in one clock domain. Compared with the first-generation register block it adds:
- a configurable channel count and sample width;
- per-channel range configuration;
- latest-sample readback with sticky overrun flags;
- byte-enable-qualified writes with a write acknowledge;
- a self-timed soft-reset pulse.

---
 rtl/ads868x_up_regbank.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ads868x_up_regbank.sv
// ads868x_up_regbank: up_* register bank for the ADS868x capture core.
// Holds configuration for the sequencer and captures the latest sample per channel.
// It also keeps sticky overrun flags and generates a self-timed soft-reset pulse.
// Single clock domain; reads and writes are acknowledged one cycle after the strobe.
module ads868x_up_regbank #(
    parameter logic [31:0] C_VERSION     = 32'h20200301,
    parameter int          C_NUM_CH      = 8,
    parameter int          C_DATA_W      = 16,
    parameter int          C_SRST_CYCLES = 16
) (
    input  logic                           up_clk,
    input  logic                           up_rstn,
    input  logic                           up_wr_req,
    input  logic [9:0]                     up_wr_addr,
    input  logic [3:0]                     up_wr_be,
    input  logic [31:0]                    up_wr_data,
    output logic                           up_wr_ack,
    input  logic                           up_rd_req,
    input  logic [9:0]                     up_rd_addr,
    output logic [31:0]                    up_rd_data,
    output logic                           up_rd_ack,
    input  logic [C_NUM_CH-1:0]            smp_valid,
    input  logic [C_NUM_CH*C_DATA_W-1:0]   smp_data,
    output logic                           ctrl_soft_reset,
    output logic                           ctrl_enable,
    output logic [C_NUM_CH-1:0]            ctrl_ext_mux_en,
    output logic [C_NUM_CH*4-1:0]          ctrl_ch_range
);

    localparam logic [7:0] SRST_LOAD = 8'(C_SRST_CYCLES);

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    logic [7:0]                         srst_cnt_q, srst_cnt_d;
    logic                               srst_start, srst_active;
    logic                               enable_q;
    logic [31:0]                        scratch_q;
    logic [C_NUM_CH-1:0]                mux_q, mux_wr;
    logic [C_NUM_CH-1:0][3:0]           cfg_q;
    logic [C_NUM_CH-1:0][C_DATA_W-1:0]  data_q, data_d;
    logic [C_NUM_CH-1:0]                fresh_q, fresh_d, ovf_q, ovf_d, ovf_clr;
    logic                               wr_ack_q, rd_ack_q;
    logic [31:0]                        rd_data_q, rd_val, status_w;

    assign srst_active     = (srst_cnt_q != 8'd0);
    assign ctrl_soft_reset = srst_active;
    assign ctrl_enable     = enable_q;
    assign ctrl_ext_mux_en = mux_q;
    assign ctrl_ch_range   = cfg_q;
    assign up_wr_ack       = wr_ack_q;
    assign up_rd_ack       = rd_ack_q;
    assign up_rd_data      = rd_data_q;

    // Soft-reset counter: a W1 to CTRL[0] (re)loads it, otherwise it counts down to 0.
    always_comb begin
        srst_start = up_wr_req && (up_wr_addr == 10'h001) && up_wr_be[0] && up_wr_data[0];
        if (srst_start)
            srst_cnt_d = SRST_LOAD;
        else if (srst_cnt_q != 8'd0)
            srst_cnt_d = srst_cnt_q - 8'd1;
        else
            srst_cnt_d = srst_cnt_q;
    end

    // Byte-lane qualified next values for MUX_EN and the OVF W1C mask.
    always_comb begin
        for (int k = 0; k < C_NUM_CH; k++) begin
            mux_wr[k]  = up_wr_be[k/8] ? up_wr_data[k] : mux_q[k];
            ovf_clr[k] = up_wr_req && (up_wr_addr == 10'h005) && up_wr_be[k/8] && up_wr_data[k];
        end
    end

    // Per-channel capture: a same-cycle CH_DATA read suppresses both the fresh clear and the overrun.
    // Overrun set wins over W1C; the whole capture state is held at 0 while the pulse runs.
    always_comb begin
        data_d  = data_q;
        fresh_d = fresh_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < C_NUM_CH; k++) begin
            if (srst_cnt_d != 8'd0) begin
                data_d[k]  = '0;
                fresh_d[k] = 1'b0;
                ovf_d[k]   = 1'b0;
            end else begin
                if (smp_valid[k]) begin
                    data_d[k]  = smp_data[k*C_DATA_W +: C_DATA_W];
                    fresh_d[k] = 1'b1;
                end else if (up_rd_req && (up_rd_addr == 10'(32 + k))) begin
                    fresh_d[k] = 1'b0;
                end
                if (smp_valid[k] && fresh_q[k] && !(up_rd_req && (up_rd_addr == 10'(32 + k))))
                    ovf_d[k] = 1'b1;
                else if (ovf_clr[k])
                    ovf_d[k] = 1'b0;
            end
        end
    end

    // Read mux over the current (pre-write) register state; unmapped words return DEADBEEF.
    always_comb begin
        status_w                  = '0;
        status_w[0]               = srst_active;
        status_w[16 +: C_NUM_CH]  = fresh_q;
        rd_val = 32'hDEADBEEF;
        case (up_rd_addr)
            10'h000: rd_val = C_VERSION;
            10'h001: rd_val = {30'd0, enable_q, srst_active};
            10'h002: rd_val = status_w;
            10'h003: rd_val = scratch_q;
            10'h004: rd_val = 32'(mux_q);
            10'h005: rd_val = 32'(ovf_q);
            default: ;
        endcase
        for (int k = 0; k < C_NUM_CH; k++) begin
            if (up_rd_addr == 10'(16 + k)) rd_val = {28'd0, cfg_q[k]};
            if (up_rd_addr == 10'(32 + k)) rd_val = 32'(data_q[k]);
        end
    end

    // State registers, configuration writes and the bus acknowledges.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            srst_cnt_q <= '0;
            enable_q   <= 1'b0;
            scratch_q  <= '0;
            mux_q      <= '0;
            cfg_q      <= '0;
            data_q     <= '0;
            fresh_q    <= '0;
            ovf_q      <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            srst_cnt_q <= srst_cnt_d;
            data_q     <= data_d;
            fresh_q    <= fresh_d;
            ovf_q      <= ovf_d;
            wr_ack_q   <= up_wr_req;
            rd_ack_q   <= up_rd_req;
            if (up_rd_req)
                rd_data_q <= rd_val;
            if (up_wr_req) begin
                if (up_wr_addr == 10'h001 && up_wr_be[0]) enable_q  <= up_wr_data[1];
                if (up_wr_addr == 10'h003)                scratch_q <= be_merge(scratch_q, up_wr_data, up_wr_be);
                if (up_wr_addr == 10'h004)                mux_q     <= mux_wr;
                for (int k = 0; k < C_NUM_CH; k++)
                    if (up_wr_addr == 10'(16 + k) && up_wr_be[0]) cfg_q[k] <= up_wr_data[3:0];
            end
        end
    end

endmodule
